// File: rtl/lcd_wb_feeder.sv
// Wishbone master feeding the wb_lcd slave: buffers {cmd,byte} entries in a FIFO and
// issues one single write per entry to the LCD data or instruction register.
module lcd_wb_feeder #(
  parameter int               DAT_W     = 32,
  parameter int               ADR_W     = 8,
  parameter logic [ADR_W-1:0] DATA_ADDR = 8'h00,
  parameter logic [ADR_W-1:0] CMD_ADDR  = 8'h04,
  parameter int               DEPTH     = 16,
  parameter int               GAP_CYC   = 2,
  parameter int               TIMEOUT   = 1024
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [7:0]               s_data,
  input  logic                     s_cmd,
  output logic [ADR_W-1:0]         wbm_adr_o,
  output logic [DAT_W-1:0]         wbm_dat_o,
  output logic                     wbm_we_o,
  output logic                     wbm_cyc_o,
  output logic                     wbm_stb_o,
  input  logic                     wbm_ack_i,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     err_timeout,
  input  logic                     err_clr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int GP_W  = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [GP_W-1:0]  GP_LAST  = GP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_GAP
  } state_t;

  // FIFO storage and bookkeeping
  logic [8:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             push;
  logic             pop;
  logic [8:0]       head;

  // Bus-side state, all outputs registered
  state_t           state_q;
  logic             cyc_q;
  logic [ADR_W-1:0] adr_q;
  logic [DAT_W-1:0] dat_q;
  logic [TO_W-1:0]  to_cnt_q;
  logic [GP_W-1:0]  gap_cnt_q;
  logic             err_q;
  logic             timeout_hit;

  // Full blocks a push even when a pop happens on the same edge.
  assign s_ready = (level_q != FULL_LVL);
  assign push    = s_valid & s_ready;
  assign pop     = (state_q == ST_IDLE) && (level_q != '0);
  assign head    = mem_q[rd_ptr_q];

  always_ff @(posedge wb_clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {s_cmd, s_data};
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      level_d = level_q + 1'b1;
    end else if (!push && pop) begin
      level_d = level_q - 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // An ack arriving on the last permitted cycle wins over the timeout.
  assign timeout_hit = (TIMEOUT != 0) && (state_q == ST_REQ) && !wbm_ack_i &&
                       (to_cnt_q == TO_LAST);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= ST_IDLE;
      cyc_q     <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      to_cnt_q  <= '0;
      gap_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (level_q != '0) begin
            adr_q    <= head[8] ? CMD_ADDR : DATA_ADDR;
            dat_q    <= DAT_W'(head[7:0]);
            cyc_q    <= 1'b1;
            to_cnt_q <= '0;
            state_q  <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (wbm_ack_i) begin
            cyc_q     <= 1'b0;
            gap_cnt_q <= '0;
            state_q   <= (GAP_CYC == 0) ? ST_IDLE : ST_GAP;
          end else if (timeout_hit) begin
            cyc_q   <= 1'b0;
            state_q <= ST_IDLE;
          end else if (TIMEOUT != 0) begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        ST_GAP: begin
          if (gap_cnt_q == GP_LAST) begin
            state_q <= ST_IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end
        default: begin
          cyc_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase

      if (err_clr) begin
        err_q <= 1'b0;
      end else if (timeout_hit) begin
        err_q <= 1'b1;
      end
    end
  end

  assign wbm_adr_o   = adr_q;
  assign wbm_dat_o   = dat_q;
  assign wbm_cyc_o   = cyc_q;
  assign wbm_stb_o   = cyc_q;
  assign wbm_we_o    = cyc_q;
  assign busy        = (state_q != ST_IDLE) || (level_q != '0);
  assign fifo_level  = level_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_lcd_wb_feeder.sv
// Self-checking bench for lcd_wb_feeder: hand-written table and corner sequences plus
// randomized traffic checked against a timestamp/queue reference model.
module tb_lcd_wb_feeder;

  localparam int DEPTH   = 16;
  localparam int GAP_CYC = 2;
  localparam int TIMEOUT = 8;
  localparam logic [7:0] DATA_ADDR = 8'h00;
  localparam logic [7:0] CMD_ADDR  = 8'h04;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, s_valid, s_ready, s_cmd, ack, err_clr;
  logic        we, cyc, stb, busy, err_timeout;
  logic [7:0]  s_data, adr;
  logic [31:0] dat;
  logic [4:0]  level;

  lcd_wb_feeder #(
    .DAT_W(32), .ADR_W(8), .DATA_ADDR(DATA_ADDR), .CMD_ADDR(CMD_ADDR),
    .DEPTH(DEPTH), .GAP_CYC(GAP_CYC), .TIMEOUT(TIMEOUT)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_cmd(s_cmd), .wbm_adr_o(adr), .wbm_dat_o(dat),
    .wbm_we_o(we), .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_ack_i(ack),
    .busy(busy), .fifo_level(level), .err_timeout(err_timeout), .err_clr(err_clr)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: queue of accepted entries plus edge timestamps.
  logic [8:0] q[$];
  bit         m_active = 1'b0;
  logic [8:0] m_cur = '0;
  int         m_start = 0;
  int         m_next_ok = 0;
  int         m_edge = 0;
  bit         m_err = 1'b0;
  bit         m_rst_seen = 1'b0;

  logic       prev_cyc = 1'b0;
  logic [15:0] wr_log[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    int  sz;
    bit  to;
    bit  acc;
    m_edge++;
    if (rst) begin
      q.delete();
      m_active   = 1'b0;
      m_next_ok  = m_edge + 1;
      m_err      = 1'b0;
      m_rst_seen = 1'b1;
    end else begin
      m_rst_seen = 1'b0;
      sz  = q.size();
      to  = 1'b0;
      acc = s_valid && (sz < DEPTH);
      if (m_active) begin
        if (ack) begin
          m_active  = 1'b0;
          m_next_ok = m_edge + GAP_CYC + 1;
        end else if (TIMEOUT != 0 && (m_edge - m_start) == TIMEOUT) begin
          m_active  = 1'b0;
          to        = 1'b1;
          m_next_ok = m_edge + 1;
        end
      end else if (m_edge >= m_next_ok && sz > 0) begin
        m_cur    = q.pop_front();
        m_active = 1'b1;
        m_start  = m_edge;
      end
      if (acc) q.push_back({s_cmd, s_data});
      if (err_clr) m_err = 1'b0;
      else if (to) m_err = 1'b1;
    end
  endtask

  task automatic check_outputs();
    bit exp_busy;
    exp_busy = (q.size() > 0) || m_active || (m_edge < m_next_ok - 1);
    chk("cyc", {31'd0, cyc}, {31'd0, m_active});
    chk("stb", {31'd0, stb}, {31'd0, m_active});
    chk("we", {31'd0, we}, {31'd0, m_active});
    if (m_active) begin
      chk("adr", {24'd0, adr}, {24'd0, (m_cur[8] ? CMD_ADDR : DATA_ADDR)});
      chk("dat", dat, {24'd0, m_cur[7:0]});
    end
    if (m_rst_seen) begin
      chk("rst_adr", {24'd0, adr}, 32'd0);
      chk("rst_dat", dat, 32'd0);
    end
    chk("level", {27'd0, level}, q.size());
    chk("s_ready", {31'd0, s_ready}, {31'd0, (q.size() < DEPTH)});
    chk("err_timeout", {31'd0, err_timeout}, {31'd0, m_err});
    chk("busy", {31'd0, busy}, {31'd0, exp_busy});
    if (cyc === 1'b1 && prev_cyc !== 1'b1) wr_log.push_back({adr, dat[7:0]});
    prev_cyc = cyc;
  endtask

  task automatic step(input logic r, input logic v, input logic [7:0] d, input logic c,
                      input logic a, input logic cl);
    rst = r; s_valid = v; s_data = d; s_cmd = c; ack = a; err_clr = cl;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  typedef struct {
    logic       rst, v;
    logic [7:0] d;
    logic       c, a, cl;
    logic       e_cyc;
    logic [4:0] e_lvl;
    logic       e_busy;
    logic [7:0] e_adr, e_dat;
  } vec_t;

  vec_t tbl[10];
  logic [15:0] exp_wr[3];

  initial begin
    int run;
    bit dropped;
    bit saw_full;
    int max_lvl;
    logic [7:0] cnt;
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_cmd = 1'b0; ack = 1'b0; err_clr = 1'b0;

    // Single character write with 4-cycle ack, stray acks in GAP and IDLE
    tbl[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 8'h00, 8'h00};
    tbl[1] = '{1'b0, 1'b1, 8'h41, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 1'b1, 8'h00, 8'h00};
    tbl[2] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b1, 8'h00, 8'h41};
    tbl[3] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b1, 8'h00, 8'h41};
    tbl[4] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b1, 8'h00, 8'h41};
    tbl[5] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b1, 8'h00, 8'h41};
    tbl[6] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 8'h00, 8'h00};
    tbl[7] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 8'h00, 8'h00};
    tbl[8] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 8'h00, 8'h00};
    tbl[9] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 8'h00, 8'h00};
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].rst, tbl[i].v, tbl[i].d, tbl[i].c, tbl[i].a, tbl[i].cl);
      chk($sformatf("tbl%0d_cyc", i), {31'd0, cyc}, {31'd0, tbl[i].e_cyc});
      chk($sformatf("tbl%0d_level", i), {27'd0, level}, {27'd0, tbl[i].e_lvl});
      chk($sformatf("tbl%0d_busy", i), {31'd0, busy}, {31'd0, tbl[i].e_busy});
      if (tbl[i].e_cyc) begin
        chk($sformatf("tbl%0d_adr", i), {24'd0, adr}, {24'd0, tbl[i].e_adr});
        chk($sformatf("tbl%0d_dat", i), dat, {24'd0, tbl[i].e_dat});
      end
    end

    // Instruction then two characters, written in push order
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    wr_log.delete();
    step(1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h48, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h49, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) step(1'b0, 1'b0, 8'h00, 1'b0, cyc, 1'b0);
    exp_wr[0] = 16'h0401; exp_wr[1] = 16'h0048; exp_wr[2] = 16'h0049;
    chk("t2_nwrites", wr_log.size(), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < wr_log.size()) chk($sformatf("t2_write%0d", i), {16'd0, wr_log[i]}, {16'd0, exp_wr[i]});
    end

    // Ack held low while flooding the FIFO
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    saw_full = 1'b0; max_lvl = 0; cnt = 8'h10;
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'b1, cnt, 1'b0, 1'b0, 1'b0);
      cnt++;
      if (level == 5'd16 && s_ready == 1'b0) saw_full = 1'b1;
      if (int'(level) > max_lvl) max_lvl = int'(level);
    end
    chk("t3_full_seen", {31'd0, saw_full}, 32'd1);
    chk("t3_max_level", max_lvl, DEPTH);
    for (int i = 0; i < 120; i++) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Timeout: first write abandoned after TIMEOUT cycles, second issued, error cleared
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h02, 1'b1, 1'b0, 1'b0);
    run = (cyc === 1'b1) ? 1 : 0;
    dropped = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      if (cyc === 1'b1 && !dropped) run++;
      else dropped = 1'b1;
    end
    chk("t4_cyc_run", run, TIMEOUT);
    chk("t4_err_set", {31'd0, err_timeout}, 32'd1);
    chk("t4_next_adr", {24'd0, adr}, {24'd0, CMD_ADDR});
    chk("t4_next_cyc", {31'd0, cyc}, 32'd1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    chk("t4_err_clr", {31'd0, err_timeout}, 32'd0);

    // Reset mid-transaction with bytes queued, then stray acks
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 8'h60 + 8'(i), 1'b0, 1'b0, 1'b0);
    chk("t5_pre_cyc", {31'd0, cyc}, 32'd1);
    chk("t5_pre_level", {27'd0, level}, 32'd5);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("t5_cyc", {31'd0, cyc}, 32'd0);
    chk("t5_level", {27'd0, level}, 32'd0);
    chk("t5_ready", {31'd0, s_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      chk("t5_no_bus", {31'd0, cyc}, 32'd0);
    end

    // Randomized traffic against the reference model
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 599) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0,
           8'($urandom),
           1'($urandom),
           ($urandom_range(0, (i < 1500) ? 3 : 11) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
